// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : 640x480@60 timing constants, frame-total helper, FSM state
//                type and colour-bar constants for vga_timing_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 timing (pixels / lines)
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_lock_wait = 16;

    // Total period of one axis (active + porches + sync)
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total_default();
        return timing_total(c_h_active, c_h_fp, c_h_sync, c_h_bp);
    endfunction

    function automatic int v_total_default();
        return timing_total(c_v_active, c_v_fp, c_v_sync, c_v_bp);
    endfunction

    // Lock-qualification FSM states
    typedef enum logic [0:0] {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_t;

    // Test-pattern colour bars, left to right
    localparam int          c_bar_width   = 80;
    localparam int          c_num_bars    = 8;
    localparam logic [23:0] c_bar_white   = 24'hFFFFFF;
    localparam logic [23:0] c_bar_yellow  = 24'hFFFF00;
    localparam logic [23:0] c_bar_cyan    = 24'h00FFFF;
    localparam logic [23:0] c_bar_green   = 24'h00FF00;
    localparam logic [23:0] c_bar_magenta = 24'hFF00FF;
    localparam logic [23:0] c_bar_red     = 24'hFF0000;
    localparam logic [23:0] c_bar_blue    = 24'h0000FF;
    localparam logic [23:0] c_bar_black   = 24'h000000;

    // Colour of the bar containing pixel column px (bar = px / 80)
    function automatic logic [23:0] bar_colour(input logic [9:0] px);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < c_num_bars; i++) begin
            if (int'(px) >= i * c_bar_width) begin
                idx = 3'(i);
            end
        end
        case (idx)
            3'd0:    return c_bar_white;
            3'd1:    return c_bar_yellow;
            3'd2:    return c_bar_cyan;
            3'd3:    return c_bar_green;
            3'd4:    return c_bar_magenta;
            3'd5:    return c_bar_red;
            3'd6:    return c_bar_blue;
            default: return c_bar_black;
        endcase
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_lock_qual.sv
`default_nettype none
// ============================================================================
//  Module      : vga_lock_qual
//  Description : Synchronizes the PLL lock flag into the pixel domain and
//                qualifies it for LOCK_WAIT consecutive cycles before
//                declaring RUN. Any loss of lock drops straight back to
//                WAIT_LOCK.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_lock_qual
    import vga_pkg::*;
#(
    parameter int LOCK_WAIT = 16
) (
    input  logic refclk,
    input  logic rst,
    input  logic i_locked,
    output logic o_lk_s,
    output logic o_running
);

    localparam int              c_qw        = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [c_qw-1:0] c_qual_last = c_qw'(LOCK_WAIT - 1);

    logic            r_sync1;
    logic            r_lk_s;
    vga_state_t      r_state;
    logic [c_qw-1:0] r_qual;
    logic            r_running;

    // Two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_lk_s  <= 1'b0;
        end else begin
            r_sync1 <= i_locked;
            r_lk_s  <= r_sync1;
        end
    end

    // Qualification FSM; running is registered alongside the state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= WAIT_LOCK;
            r_qual    <= '0;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (!r_lk_s) begin
                        r_qual <= '0;
                    end else if (r_qual == c_qual_last) begin
                        r_state   <= RUN;
                        r_qual    <= '0;
                        r_running <= 1'b1;
                    end else begin
                        r_qual <= r_qual + 1'b1;
                    end
                end
                RUN: begin
                    if (!r_lk_s) begin
                        r_state   <= WAIT_LOCK;
                        r_qual    <= '0;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= WAIT_LOCK;
                    r_qual    <= '0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign o_lk_s    = r_lk_s;
    assign o_running = r_running;

endmodule : vga_lock_qual
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 VGA timing generator. Produces registered
//                hsync/vsync/de, pixel coordinates and line/frame strobes,
//                held inactive until PLL lock is qualified.
//                Optional macro VGA_TEST_PATTERN_EN adds a 24-bit colour-bar
//                output `rgb`.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = c_h_active,
    parameter int   H_FP      = c_h_fp,
    parameter int   H_SYNC    = c_h_sync,
    parameter int   H_BP      = c_h_bp,
    parameter int   V_ACTIVE  = c_v_active,
    parameter int   V_FP      = c_v_fp,
    parameter int   V_SYNC    = c_v_sync,
    parameter int   V_BP      = c_v_bp,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   LOCK_WAIT = c_lock_wait
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic        running
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [23:0] rgb
`endif
);

    localparam int c_h_total = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_first   = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_last    = c_hw'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_first   = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_last    = c_vw'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic            w_lk_s;
    logic            w_running;
    logic            w_adv;
    logic            w_de;
    logic            w_hs;
    logic            w_vs;
    logic [c_hw-1:0] r_h_cnt;
    logic [c_vw-1:0] r_v_cnt;

    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic            r_line_start;
    logic            r_frame_start;

    vga_lock_qual #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_qual (
        .refclk    (refclk),
        .rst       (rst),
        .i_locked  (locked),
        .o_lk_s    (w_lk_s),
        .o_running (w_running)
    );

    // Counters only advance in RUN while lock is still present; a lock drop
    // in RUN clears them in the same cycle the FSM leaves RUN.
    assign w_adv = w_running & w_lk_s;

    assign w_de = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs = (r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last);
    assign w_vs = (r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last);

    // Horizontal / vertical raster counters, wrapping together at frame end
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_adv) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Registered decode: outputs trail the counters by one cycle
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!w_adv) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hs ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_de;
            r_x           <= w_de ? 10'(r_h_cnt) : 10'd0;
            r_y           <= w_de ? 10'(r_v_cnt) : 10'd0;
            r_line_start  <= (r_h_cnt == '0);
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] r_rgb;

    // Colour bars, aligned with de and black outside active video
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (w_adv && w_de) begin
            r_rgb <= bar_colour(10'(r_h_cnt));
        end else begin
            r_rgb <= '0;
        end
    end

    assign rgb = r_rgb;
`endif

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign running     = w_running;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Horizontal timing is
//                the real 640-pixel line; the frame is shortened to 15 lines
//                so several frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int   HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int   VA = 8,   VF = 2,  VS = 2,  VB = 3;
    localparam int   LW = 16;
    localparam logic POL = 1'b0;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FRAME = HT * VT;

    logic        refclk = 1'b0;
    logic        rst    = 1'b1;
    logic        locked = 1'b0;
    logic        hsync, vsync, de, line_start, frame_start, running;
    logic [9:0]  x, y;
`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] rgb;
`endif

    int checks = 0;
    int errors = 0;

    always #20 refclk = ~refclk;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL), .LOCK_WAIT (LW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .running     (running)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb       (rgb)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: m_streak = number of consecutive edges at which the
    // synchronized lock was seen high. RUN after LW such edges; each extra
    // edge is one raster position since the start of the frame.
    // ------------------------------------------------------------------
    logic m_s1, m_s2;
    int   m_streak;

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_s1     <= 1'b0;
            m_s2     <= 1'b0;
            m_streak <= 0;
        end else begin
            m_s1     <= locked;
            m_s2     <= m_s1;
            m_streak <= m_s2 ? m_streak + 1 : 0;
        end
    end

    function automatic logic [25:0] exp_vec(input int s);
        int t, h, v;
        logic run, act, e_de, e_hs, e_vs, e_ls, e_fs;
        logic [9:0] ex, ey;
        run  = (s >= LW);
        act  = (s >= LW + 1);
        t    = act ? (s - LW - 1) : 0;
        h    = t % HT;
        v    = (t / HT) % VT;
        e_de = act && (h < HA) && (v < VA);
        e_hs = act && (h >= HA + HF) && (h < HA + HF + HS);
        e_vs = act && (v >= VA + VF) && (v < VA + VF + VS);
        e_ls = act && (h == 0);
        e_fs = e_ls && (v == 0);
        ex   = e_de ? 10'(h) : 10'd0;
        ey   = e_de ? 10'(v) : 10'd0;
        return {run, e_de, (e_hs ? POL : ~POL), (e_vs ? POL : ~POL), e_ls, e_fs, ex, ey};
    endfunction

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [23:0] exp_rgb(input int s);
        int t, h, v;
        if (s < LW + 1) return 24'h0;
        t = s - LW - 1;
        h = t % HT;
        v = (t / HT) % VT;
        if (!(h < HA && v < VA)) return 24'h0;
        case (h / 80)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction
`endif

    wire [25:0] w_got = {running, de, hsync, vsync, line_start, frame_start, x, y};

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge refclk);
        checks++;
        if (w_got !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", w_got,
                     {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});
        end
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge refclk);
            checks++;
            if (w_got !== exp_vec(m_streak) || running !== 1'b0 || de !== 1'b0 ||
                hsync !== 1'b1 || vsync !== 1'b1) begin
                errors++;
                $display("FAIL unlocked_idle cyc %0d: got %h required %h", i, w_got, exp_vec(m_streak));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_lock_acquire();
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge refclk);
            checks++;
            if (w_got !== exp_vec(m_streak)) begin
                errors++;
                $display("FAIL acquire_model cyc %0d: got %h required %h", i, w_got, exp_vec(m_streak));
            end
            if (running === 1'b1) begin
                n = i;
                found = 1'b1;
            end
        end
        checks++;
        if (!found || n < 17 || n > 19) begin
            errors++;
            $display("FAIL lock_latency: got %0d cycles (found=%0d) required 18+-1", n, found);
        end
        @(negedge refclk);
        checks++;
        if ({frame_start, line_start, de, x, y} !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL first_pixel: got fs=%b ls=%b de=%b x=%0d y=%0d required 1 1 1 0 0",
                     frame_start, line_start, de, x, y);
        end
    endtask

    // ------------------------------------------------------------------
    // Starts on the cycle right after the first frame_start was observed.
    task automatic test_frames();
        int last_fs, last_ls, line_de, frame_de, hs_start, vs_start, n_fs, n_vs;
        logic prev_hs, prev_vs;
        last_fs = 0; last_ls = 0; line_de = 1; frame_de = 1;
        hs_start = 0; vs_start = 0; n_fs = 0; n_vs = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge refclk);
            checks++;
            if (w_got !== exp_vec(m_streak)) begin
                errors++;
                $display("FAIL frame_model cyc %0d: got %h required %h", i, w_got, exp_vec(m_streak));
            end
`ifdef VGA_TEST_PATTERN_EN
            checks++;
            if (rgb !== exp_rgb(m_streak)) begin
                errors++;
                $display("FAIL rgb cyc %0d x=%0d: got %h required %h", i, x, rgb, exp_rgb(m_streak));
            end
            if (de === 1'b1 && y === 10'd0 && (x === 10'd0 || x === 10'd80 || x === 10'd639)) begin
                checks++;
                if (rgb !== ((x === 10'd0) ? 24'hFFFFFF : (x === 10'd80) ? 24'hFFFF00 : 24'h000000)) begin
                    errors++;
                    $display("FAIL rgb_point x=%0d: got %h", x, rgb);
                end
            end
`endif
            if (frame_start === 1'b1) begin
                n_fs++;
                checks++;
                if (i - last_fs != FRAME || frame_de != HA * VA) begin
                    errors++;
                    $display("FAIL frame_period: got %0d cyc %0d de, required %0d cyc %0d de",
                             i - last_fs, frame_de, FRAME, HA * VA);
                end
                last_fs = i;
                frame_de = 0;
            end
            if (line_start === 1'b1) begin
                checks++;
                if (i - last_ls != HT || (line_de != 0 && line_de != HA)) begin
                    errors++;
                    $display("FAIL line_period: got %0d cyc %0d de, required %0d cyc %0d de",
                             i - last_ls, line_de, HT, HA);
                end
                last_ls = i;
                line_de = 0;
            end
            if (de === 1'b1) begin
                line_de++;
                frame_de++;
            end
            if (prev_hs === 1'b1 && hsync === 1'b0) begin
                hs_start = i;
                checks++;
                if (i - last_ls != HA + HF) begin
                    errors++;
                    $display("FAIL hsync_start: got %0d required %0d", i - last_ls, HA + HF);
                end
            end
            if (prev_hs === 1'b0 && hsync === 1'b1) begin
                checks++;
                if (i - hs_start != HS) begin
                    errors++;
                    $display("FAIL hsync_width: got %0d required %0d", i - hs_start, HS);
                end
            end
            if (prev_vs === 1'b1 && vsync === 1'b0) vs_start = i;
            if (prev_vs === 1'b0 && vsync === 1'b1) begin
                n_vs++;
                checks++;
                if (i - vs_start != VS * HT) begin
                    errors++;
                    $display("FAIL vsync_width: got %0d required %0d", i - vs_start, VS * HT);
                end
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
        checks++;
        if (n_fs != 2 || n_vs != 2) begin
            errors++;
            $display("FAIL frame_events: got %0d frame_start %0d vsync pulses required 2 2", n_fs, n_vs);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_lock_glitch();
        int drop_at, run_at, fs_at;
        drop_at = 0; run_at = 0; fs_at = 0;
        repeat ($urandom_range(50, 500)) begin
            @(negedge refclk);
            checks++;
            if (w_got !== exp_vec(m_streak)) begin
                errors++;
                $display("FAIL glitch_pre: got %h required %h", w_got, exp_vec(m_streak));
            end
        end
        locked = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge refclk);
            if (i == 1) locked = 1'b1;
            checks++;
            if (w_got !== exp_vec(m_streak)) begin
                errors++;
                $display("FAIL glitch_model cyc %0d: got %h required %h", i, w_got, exp_vec(m_streak));
            end
            if (drop_at == 0 && running === 1'b0 && de === 1'b0) drop_at = i;
            if (drop_at != 0 && run_at == 0 && running === 1'b1) run_at = i;
            if (fs_at == 0 && frame_start === 1'b1) fs_at = i;
        end
        checks++;
        if (drop_at < 1 || drop_at > 3) begin
            errors++;
            $display("FAIL glitch_drop: got %0d required 1..3", drop_at);
        end
        checks++;
        if (run_at != 19 || fs_at != 20) begin
            errors++;
            $display("FAIL glitch_relock: got run %0d fs %0d required 19 20", run_at, fs_at);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midframe();
        bit hit;
        int run_at, fs_at;
        hit = 1'b0; run_at = 0; fs_at = 0;
        for (int i = 0; i < FRAME && !hit; i++) begin
            @(negedge refclk);
            checks++;
            if (w_got !== exp_vec(m_streak)) begin
                errors++;
                $display("FAIL midframe_model: got %h required %h", w_got, exp_vec(m_streak));
            end
            if (de === 1'b1 && x === 10'd300 && y === 10'd5) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midframe_reach: got no x=300 y=5 required one");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (w_got !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", w_got,
                     {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0});
        end
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge refclk);
            checks++;
            if (w_got !== exp_vec(m_streak)) begin
                errors++;
                $display("FAIL post_reset_model cyc %0d: got %h required %h", i, w_got, exp_vec(m_streak));
            end
            if (run_at == 0 && running === 1'b1) run_at = i;
            if (fs_at == 0 && frame_start === 1'b1) fs_at = i;
        end
        checks++;
        if (run_at != 18 || fs_at != 19) begin
            errors++;
            $display("FAIL post_reset_requal: got run %0d fs %0d required 18 19", run_at, fs_at);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_lock();
        int hold;
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge refclk);
            checks++;
            if (w_got !== exp_vec(m_streak)) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %h required %h", i, w_got, exp_vec(m_streak));
            end
            if (hold == 0) begin
                locked = ~locked;
                if (locked)
                    hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(20, 1500));
                else
                    hold = int'($urandom_range(1, 6));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 1499) == 0) begin
                #7 rst = 1'b1;
                #10 rst = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_lock_acquire();
        test_frames();
        test_lock_glitch();
        test_reset_midframe();
        test_random_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(200000 * 40);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
